spram_stream_rd: RTL and testbench

SPRAM_STREAM_RD -- requirements
Module: spram_stream_rd

---
 rtl/spram_stream_rd_if.sv | 46 ++++
 rtl/spram_stream_rd.sv | 153 +++++++++++++++
 tb/tb_spram_stream_rd.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_stream_rd_if.sv
// Bundle of the control, SPRAM read-port and output-stream signals of spram_stream_rd.
// master: the reader block itself. slave: the surrounding system (CPU, arbiter, sink).
interface spram_stream_rd_if #(
    parameter int unsigned AW = 14
);
    // Transfer control
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_len;
    logic          cfg_loop;
    logic          start;
    logic          stop;
    logic          busy;
    logic          done;

    // SPRAM port (read-only use)
    logic          sp_req;
    logic          sp_gnt;
    logic [AW-1:0] sp_addr;
    logic [31:0]   sp_rdata;
    logic [31:0]   sp_wdata;
    logic [3:0]    sp_wmsk;
    logic          sp_we;

    // Output stream
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        input  cfg_base, cfg_len, cfg_loop, start, stop,
        output busy, done,
        output sp_req, sp_addr, sp_wdata, sp_wmsk, sp_we,
        input  sp_gnt, sp_rdata,
        output out_data, out_valid,
        input  out_ready
    );

    modport slave (
        output cfg_base, cfg_len, cfg_loop, start, stop,
        input  busy, done,
        input  sp_req, sp_addr, sp_wdata, sp_wmsk, sp_we,
        output sp_gnt, sp_rdata,
        input  out_data, out_valid,
        output out_ready
    );
endinterface

// File: rtl/spram_stream_rd.sv
// Streams a block of SPRAM words (optionally circular) into a small FIFO and out on a
// valid/ready stream. Reads are only issued when the FIFO is guaranteed to have room for the
// returning word, so read data is never dropped.
module spram_stream_rd #(
    parameter int unsigned AW    = 14,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    spram_stream_rd_if.master  bus_io
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;     // reads issued in the current pass
    logic          loop_q, loop_d;
    logic          done_q, done_d;
    logic          inflight_q;       // a read was granted last cycle; its data arrives now

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;

    logic words_left;
    logic room;
    logic rd_fire;
    logic fifo_wr;
    logic fifo_rd;

    // Request generation: occupancy plus the pending word must leave a free slot.
    always_comb begin
        words_left = loop_q || (cnt_q != len_q);
        room       = (count_q + CW'(inflight_q)) < CW'(DEPTH);
        bus_io.sp_req = (state_q == StRun) && words_left && room;
        rd_fire    = bus_io.sp_req && bus_io.sp_gnt;
        fifo_wr    = inflight_q && !bus_io.stop;
        fifo_rd    = bus_io.out_valid && bus_io.out_ready;
    end

    // Status, address and stream outputs; the write side of the SPRAM port is unused.
    always_comb begin
        bus_io.busy      = (state_q != StIdle);
        bus_io.done      = done_q;
        bus_io.sp_addr   = addr_q;
        bus_io.sp_wdata  = '0;
        bus_io.sp_wmsk   = '0;
        bus_io.sp_we     = 1'b0;
        bus_io.out_valid = (count_q != '0);
        bus_io.out_data  = (count_q != '0) ? mem_q[rptr_q] : '0;
    end

    // Next-state logic: transfer sequencing and address walk.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start && !bus_io.stop) begin
                    base_d = bus_io.cfg_base;
                    len_d  = bus_io.cfg_len;
                    loop_d = bus_io.cfg_loop;
                    addr_d = bus_io.cfg_base;
                    cnt_d  = '0;
                    if (bus_io.cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (bus_io.stop) begin
                    state_d = StIdle;
                end else if (rd_fire) begin
                    if (cnt_q + (AW+1)'(1) == len_q) begin
                        if (loop_q) begin
                            addr_d = base_q;
                            cnt_d  = '0;
                        end else begin
                            addr_d  = addr_q + AW'(1);
                            cnt_d   = len_q;
                            state_d = StDrain;
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                        cnt_d  = cnt_q + (AW+1)'(1);
                    end
                end
            end
            StDrain: begin
                if (bus_io.stop) begin
                    state_d = StIdle;
                end else if (count_q == '0 && !inflight_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control registers; a read granted in a stop cycle is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            inflight_q <= rd_fire && !bus_io.stop;
        end
    end

    // Output FIFO; stop flushes it together with any arriving word.
    always_ff @(posedge clk) begin
        if (rst || bus_io.stop) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (fifo_wr) begin
                mem_q[wptr_q] <= bus_io.sp_rdata;
                wptr_q        <= wptr_q + PW'(1);
            end
            if (fifo_rd) begin
                rptr_q <= rptr_q + PW'(1);
            end
            count_q <= count_q + CW'(fifo_wr) - CW'(fifo_rd);
        end
    end
endmodule

// File: tb/tb_spram_stream_rd.sv
// Directed bench for spram_stream_rd: a vector table of transfers plus hand-written
// sequences for zero length, ignored start, and reset in the middle of a transfer.
module tb_spram_stream_rd;
    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spram_stream_rd_if #(.AW(AW)) bus ();

    spram_stream_rd #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [AW-1:0] rd_q[$];
    int            rd_cyc[$];
    logic [31:0]   out_q[$];
    int            done_cnt = 0;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        logic          loop;
        int            gnt_mode;    // 0: always granted, 1: pattern 1,0,0
        int            rdy_hold;    // cycles with out_ready low at the start
        int            want_words;
        int            exp_reads;   // 0: not checked (loop mode)
        int            exp_done;
        logic [AW-1:0] exp_first;
        bit            chk_consec;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {8'h5A, 8'hC3 ^ a[7:0], 2'b00, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SPRAM model: data one cycle after the read, garbage otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.sp_rdata <= (bus.sp_req && bus.sp_gnt) ? mem_word(bus.sp_addr) : 32'hDEAD_BEEF;
    end

    // Monitor away from the active edge: records traffic and checks hold rules.
    logic          hold_req_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic          hold_out_pend = 1'b0;
    logic [31:0]   hold_data;
    always @(negedge clk) begin
        if (rst) begin
            hold_req_pend = 1'b0;
            hold_out_pend = 1'b0;
        end else begin
            if (hold_req_pend) begin
                chk("sp_req held", bus.sp_req, 1);
                chk("sp_addr held", bus.sp_addr, hold_addr);
            end
            if (hold_out_pend) begin
                chk("out_valid held", bus.out_valid, 1);
                chk("out_data held", bus.out_data, hold_data);
            end
            if (bus.sp_req && bus.sp_gnt) begin
                rd_q.push_back(bus.sp_addr);
                rd_cyc.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
            if (bus.done) done_cnt++;
            hold_req_pend = bus.sp_req && !bus.sp_gnt && !bus.stop;
            hold_addr     = bus.sp_addr;
            hold_out_pend = bus.out_valid && !bus.out_ready && !bus.stop;
            hold_data     = bus.out_data;
        end
    end

    task automatic run_case(input int idx, input vec_t v);
        int  n;
        bit  finished;
        logic [AW-1:0] ea;
        rd_q.delete();
        rd_cyc.delete();
        out_q.delete();
        done_cnt      = 0;
        bus.cfg_base  = v.base;
        bus.cfg_len   = v.len;
        bus.cfg_loop  = v.loop;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        finished = 1'b0;
        while (!finished && n < 400) begin
            bus.sp_gnt    = (v.gnt_mode == 0) ? 1'b1 : ((n % 3) == 0);
            bus.out_ready = (n >= v.rdy_hold);
            if (v.rdy_hold > 0 && n == v.rdy_hold) begin
                chk("reads while stalled", rd_q.size(), DEPTH);
                chk("sp_req low while full", bus.sp_req, 0);
            end
            step();
            n++;
            if (v.loop) finished = (out_q.size() >= v.want_words);
            else        finished = (done_cnt > 0);
        end
        chk("case finished in time", finished, 1);
        if (v.loop) begin
            bus.stop      = 1'b1;
            bus.out_ready = 1'b0;
            step();
            bus.stop = 1'b0;
            chk("out_valid after stop", bus.out_valid, 0);
            chk("busy after stop", bus.busy, 0);
            chk("sp_req after stop", bus.sp_req, 0);
            step();
            chk("done after stop", bus.done, 0);
        end else begin
            chk("busy after done", bus.busy, 0);
            step();
        end
        bus.sp_gnt    = 1'b1;
        bus.out_ready = 1'b1;
        chk("done pulses", done_cnt, v.exp_done);
        chk("words delivered", out_q.size(), v.want_words);
        if (v.exp_reads > 0) chk("read count", rd_q.size(), v.exp_reads);
        if (rd_q.size() > 0) chk("first addr", rd_q[0], v.exp_first);
        else                 chk("any read issued", 0, 1);
        for (int i = 0; i < rd_q.size(); i++) begin
            ea = v.base + AW'(i % int'(v.len));
            chk($sformatf("case%0d addr[%0d]", idx, i), rd_q[i], ea);
        end
        for (int i = 0; i < out_q.size(); i++) begin
            ea = v.base + AW'(i % int'(v.len));
            chk($sformatf("case%0d data[%0d]", idx, i), out_q[i], mem_word(ea));
        end
        if (v.chk_consec) begin
            for (int i = 1; i < rd_cyc.size(); i++) begin
                chk("consecutive reads", rd_cyc[i] - rd_cyc[0], i);
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_base  = '0;
        bus.cfg_len   = '0;
        bus.cfg_loop  = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.sp_gnt    = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset sp_req", bus.sp_req, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset sp_addr", bus.sp_addr, 0);
        chk("reset out_data", bus.out_data, 0);
        chk("write port idle", {bus.sp_we, bus.sp_wmsk, bus.sp_wdata}, 0);
        rst = 1'b0;
        step();

        //           base      len   loop gnt hold want reads done first     consec
        vecs[0] = '{14'h0010, 15'd3, 1'b0, 0, 0,  3, 3, 1, 14'h0010, 1'b1};
        vecs[1] = '{14'h3FFE, 15'd4, 1'b0, 0, 0,  4, 4, 1, 14'h3FFE, 1'b1};
        vecs[2] = '{14'h0200, 15'd8, 1'b0, 0, 12, 8, 8, 1, 14'h0200, 1'b0};
        vecs[3] = '{14'h0040, 15'd5, 1'b0, 1, 0,  5, 5, 1, 14'h0040, 1'b0};
        vecs[4] = '{14'h0100, 15'd2, 1'b1, 0, 0,  6, 0, 0, 14'h0100, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_case(i, vecs[i]);
            step();
        end

        // Zero-length start: immediate done, never busy.
        done_cnt     = 0;
        bus.cfg_base = 14'h0123;
        bus.cfg_len  = '0;
        bus.cfg_loop = 1'b0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        chk("len0 done", bus.done, 1);
        chk("len0 busy", bus.busy, 0);
        step();
        chk("len0 done single", bus.done, 0);

        // start together with stop is ignored.
        bus.cfg_len = 15'd4;
        bus.start   = 1'b1;
        bus.stop    = 1'b1;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start+stop busy", bus.busy, 0);
        chk("start+stop sp_req", bus.sp_req, 0);

        // Reset the cycle after a granted read: the returning word must be dropped.
        bus.cfg_base = 14'h0300;
        bus.cfg_len  = 15'd4;
        bus.sp_gnt   = 1'b0;
        bus.start    = 1'b1;
        step();
        bus.start  = 1'b0;
        bus.sp_gnt = 1'b1;
        chk("rst case requesting", bus.sp_req, 1);
        step();
        rst        = 1'b1;
        bus.sp_gnt = 1'b0;
        step();
        chk("mid rst busy", bus.busy, 0);
        chk("mid rst done", bus.done, 0);
        chk("mid rst sp_req", bus.sp_req, 0);
        chk("mid rst out_valid", bus.out_valid, 0);
        chk("mid rst sp_addr", bus.sp_addr, 0);
        chk("mid rst out_data", bus.out_data, 0);
        rst = 1'b0;
        out_q.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no late data valid", bus.out_valid, 0);
        end
        chk("no late data delivered", out_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
